// File: rtl/key_event_fifo.sv
// key_event_fifo
//   Sits between the 4x4 keypad scanner and the display stage. The scanner's
//   active-low key level vector is synchronised, stability-filtered, and every
//   new key press (released -> pressed edge of the filtered vector) becomes a
//   4-bit key code. Codes are queued in a show-ahead FIFO and drained by the
//   display stage with a valid/ready handshake.
//
// Ports
//   clk_in      system clock, rising edge
//   rst_in      asynchronous active-high reset
//   key_out     scanner key levels, bit i = key i, 0 = pressed (asynchronous)
//   code_data   key index at the FIFO head (meaningful while code_valid = 1)
//   code_valid  FIFO non-empty
//   code_ready  consumer takes the head this cycle
//   fifo_count  entries held, 0..DEPTH
//   overflow    sticky flag: a code was dropped because the FIFO was full
//   ovf_clr     one-cycle pulse clearing overflow
//   chord       one-cycle pulse: several new presses were detected at once
module key_event_fifo #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DEPTH         = 8,
  localparam int unsigned PTR_W        = $clog2(DEPTH),
  localparam int unsigned CNT_W        = PTR_W + 1,
  localparam int unsigned STAB_W       = $clog2(STABLE_CYCLES)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [15:0]      key_out,
  output logic [3:0]       code_data,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             chord
);

  // Input conditioning: 2-flop synchroniser feeding the stability filter.
  logic [15:0]       sync1, sync2;
  logic [15:0]       candidate, stable, stable_prev;
  logic [STAB_W-1:0] stab_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1       <= 16'hFFFF;
      sync2       <= 16'hFFFF;
      candidate   <= 16'hFFFF;
      stable      <= 16'hFFFF;
      stable_prev <= 16'hFFFF;
      stab_cnt    <= '0;
    end else begin
      sync1       <= key_out;
      sync2       <= sync1;
      stable_prev <= stable;
      if (sync2 != candidate) begin
        candidate <= sync2;
        stab_cnt  <= '0;
      end else if (stab_cnt == STAB_W'(STABLE_CYCLES - 1)) begin
        // Counter saturates; stable keeps tracking the settled candidate.
        stable <= candidate;
      end else begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end
    end
  end

  // Press detection: only released -> pressed transitions of the filtered vector.
  logic [15:0] newpress;
  logic [3:0]  push_code;
  logic        push;
  logic        multi;

  assign newpress = stable_prev & ~stable;
  assign push     = |newpress;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi    = |(newpress & (newpress - 16'd1));

  always_comb begin
    push_code = 4'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (newpress[i]) begin
        push_code = 4'(i);
      end
    end
  end

  // Show-ahead FIFO.
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, accept, drop;

  assign full       = (count == CNT_W'(DEPTH));
  assign code_valid = (count != '0);
  assign pop        = code_valid & code_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign accept     = push & (~full | pop);
  assign drop       = push & full & ~pop;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 4'd0;
      end
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      chord    <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A new drop outranks a simultaneous clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      chord <= push & multi;
    end
  end

  assign code_data  = mem[rd_ptr];
  assign fifo_count = count;

endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo
//   Self-checking bench for key_event_fifo: a table of directed phases with
//   fixed expected values, a hand-written reset-while-held sequence, and a
//   randomized run, all tracked by a cycle-level reference model of the
//   filter window, press events and code queue.
module tb_key_event_fifo;
  localparam int unsigned SC    = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] key_out;
  logic [3:0]  code_data;
  logic        code_valid;
  logic        code_ready;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr;
  logic        chord;

  key_event_fifo #(.STABLE_CYCLES(SC), .DEPTH(DEPTH)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .key_out    (key_out),
    .code_data  (code_data),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .chord      (chord)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: key samples per edge, filtered vector, pending press set,
  // queue of codes, sticky overflow and chord pulse.
  logic [15:0] hist[$];
  logic [15:0] m_stable;
  logic [15:0] m_pend;
  logic [3:0]  mq[$];
  logic        m_ovf;
  logic        m_chord;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(SC) + 3; i++) hist.push_back(16'hFFFF);
    m_stable = 16'hFFFF;
    m_pend   = 16'h0;
    mq.delete();
    m_ovf    = 1'b0;
    m_chord  = 1'b0;
  endtask

  task automatic model_edge(input logic [15:0] k, input logic r, input logic c);
    logic        popped;
    logic        dropped;
    logic        same;
    logic [15:0] old;
    int          lowest;
    int          n;
    popped = (mq.size() != 0) && r;
    if (popped) void'(mq.pop_front());
    dropped = 1'b0;
    m_chord = 1'b0;
    if (m_pend != 16'h0) begin
      lowest = 0;
      while (!m_pend[lowest]) lowest++;
      if (mq.size() < int'(DEPTH)) mq.push_back(lowest[3:0]);
      else dropped = 1'b1;
      m_chord = ($countones(m_pend) >= 2);
    end
    if (dropped) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    // Filter: the value the synchroniser delivered two edges ago is accepted
    // once it has been seen unchanged over SC+1 consecutive samples.
    hist.push_back(k);
    void'(hist.pop_front());
    n = hist.size();
    same = 1'b1;
    for (int j = 2; j <= int'(SC) + 2; j++) begin
      if (hist[n-1-j] != hist[n-3]) same = 1'b0;
    end
    old = m_stable;
    if (same) m_stable = hist[n-3];
    m_pend = old & ~m_stable;
  endtask

  task automatic check_model();
    chk("model valid", 16'(code_valid), 16'(mq.size() != 0));
    chk("model count", 16'(fifo_count), 16'(mq.size()));
    chk("model overflow", 16'(overflow), 16'(m_ovf));
    chk("model chord", 16'(chord), 16'(m_chord));
    if (mq.size() != 0) chk("model data", 16'(code_data), 16'(mq[0]));
  endtask

  // One clock: inputs held across the edge, model advanced, outputs sampled 1 ns later.
  task automatic step(input logic [15:0] k, input logic r, input logic c);
    key_out    = k;
    code_ready = r;
    ovf_clr    = c;
    @(posedge clk_in);
    if (rst_in) model_reset();
    else model_edge(k, r, c);
    #1;
    check_model();
  endtask

  task automatic hold(input logic [15:0] k, input logic r, input logic c, input int n);
    for (int i = 0; i < n; i++) step(k, r, c);
  endtask

  typedef struct {
    string       name;
    logic [15:0] key;
    logic        ready;
    logic        clr;
    int          cycles;
    logic        exp_valid;
    logic [3:0]  exp_data;
    logic [3:0]  exp_count;
    logic        exp_ovf;
    logic        exp_chord;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [15:0] key, input logic ready,
                     input logic clr, input int cycles, input logic ev, input int ed,
                     input int ec, input logic eo, input logic ech);
    vec_t v;
    v.name = name; v.key = key; v.ready = ready; v.clr = clr; v.cycles = cycles;
    v.exp_valid = ev; v.exp_data = ed[3:0]; v.exp_count = ec[3:0];
    v.exp_ovf = eo; v.exp_chord = ech;
    vecs.push_back(v);
  endtask

  function automatic logic [15:0] one_key(input int i);
    logic [15:0] m;
    m = 16'h1 << i;
    return ~m;
  endfunction

  initial begin
    // Scenario 1: single press, latency 8 edges, then pop.
    add("t1 before latency", 16'hFFDF, 0, 0, 7, 0, 0, 0, 0, 0);
    add("t1 at latency",     16'hFFDF, 0, 0, 1, 1, 5, 1, 0, 0);
    add("t1 pop",            16'hFFDF, 1, 0, 1, 0, 0, 0, 0, 0);
    add("t1 release",        16'hFFFF, 0, 0, 10, 0, 0, 0, 0, 0);
    // Scenario 2: short glitch is filtered out.
    add("t2 glitch",         16'hFFFB, 0, 0, 3, 0, 0, 0, 0, 0);
    add("t2 settle",         16'hFFFF, 0, 0, 12, 0, 0, 0, 0, 0);
    // Scenario 3: chord of keys 3 and 9.
    add("t3 before latency", 16'hFDF7, 0, 0, 7, 0, 0, 0, 0, 0);
    add("t3 push",           16'hFDF7, 0, 0, 1, 1, 3, 1, 0, 1);
    add("t3 chord ends",     16'hFDF7, 0, 0, 1, 1, 3, 1, 0, 0);
    add("t3 drain",          16'hFFFF, 1, 0, 1, 0, 0, 0, 0, 0);
    add("t3 release",        16'hFFFF, 0, 0, 10, 0, 0, 0, 0, 0);
    // Scenario 4: overflow after 9 presses; clear vs. set in same cycle.
    for (int i = 0; i < 9; i++) begin
      add("t4 press",   one_key(i), 0, 0, 10, 1, 0, (i < 8) ? i + 1 : 8, i == 8, 0);
      add("t4 release", 16'hFFFF,   0, 0, 10, 1, 0, (i < 8) ? i + 1 : 8, i == 8, 0);
    end
    add("t4 10th pre",       one_key(9), 0, 0, 7, 1, 0, 8, 1, 0);
    add("t4 clr vs set",     one_key(9), 0, 1, 1, 1, 0, 8, 1, 0);
    add("t4 10th hold",      one_key(9), 0, 0, 2, 1, 0, 8, 1, 0);
    add("t4 10th release",   16'hFFFF,   0, 0, 10, 1, 0, 8, 1, 0);
    add("t4 ovf_clr",        16'hFFFF,   0, 1, 1, 1, 0, 8, 0, 0);
    for (int j = 0; j < 8; j++)
      add("t4 drain", 16'hFFFF, 1, 0, 1, j < 7, (j < 7) ? j + 1 : 0, 7 - j, 0, 0);
    // Scenario 5: full FIFO, new press coinciding with a pop.
    for (int i = 0; i < 8; i++) begin
      add("t5 fill",    one_key(i), 0, 0, 10, 1, 0, i + 1, 0, 0);
      add("t5 release", 16'hFFFF,   0, 0, 10, 1, 0, i + 1, 0, 0);
    end
    add("t5 pre",            16'hEFFF, 0, 0, 7, 1, 0, 8, 0, 0);
    add("t5 push+pop",       16'hEFFF, 1, 0, 1, 1, 1, 8, 0, 0);
    add("t5 hold",           16'hEFFF, 0, 0, 2, 1, 1, 8, 0, 0);
    add("t5 release",        16'hFFFF, 0, 0, 10, 1, 1, 8, 0, 0);
    for (int j = 0; j < 8; j++)
      add("t5 drain", 16'hFFFF, 1, 0, 1, j < 7, (j < 6) ? j + 2 : ((j == 6) ? 12 : 0), 7 - j, 0, 0);
  end

  initial begin
    rst_in     = 1'b1;
    key_out    = 16'hFFFF;
    code_ready = 1'b0;
    ovf_clr    = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    chk("reset valid", 16'(code_valid), 16'd0);
    chk("reset data", 16'(code_data), 16'd0);
    chk("reset count", 16'(fifo_count), 16'd0);
    chk("reset overflow", 16'(overflow), 16'd0);
    chk("reset chord", 16'(chord), 16'd0);
    rst_in = 1'b0;
    hold(16'hFFFF, 0, 0, 3);

    foreach (vecs[i]) begin
      hold(vecs[i].key, vecs[i].ready, vecs[i].clr, vecs[i].cycles);
      chk({vecs[i].name, " valid"}, 16'(code_valid), 16'(vecs[i].exp_valid));
      chk({vecs[i].name, " count"}, 16'(fifo_count), 16'(vecs[i].exp_count));
      chk({vecs[i].name, " overflow"}, 16'(overflow), 16'(vecs[i].exp_ovf));
      chk({vecs[i].name, " chord"}, 16'(chord), 16'(vecs[i].exp_chord));
      if (vecs[i].exp_valid)
        chk({vecs[i].name, " data"}, 16'(code_data), 16'(vecs[i].exp_data));
    end

    // Scenario 6: reset while key A held and 3 codes queued.
    hold(one_key(0), 0, 0, 10);
    hold(16'hFFFF, 0, 0, 10);
    hold(one_key(1), 0, 0, 10);
    hold(16'hFFFF, 0, 0, 10);
    hold(16'hFBFF, 0, 0, 10);
    chk("t6 queued", 16'(fifo_count), 16'd3);
    rst_in = 1'b1;
    #1;
    chk("t6 async count", 16'(fifo_count), 16'd0);
    chk("t6 async valid", 16'(code_valid), 16'd0);
    model_reset();
    hold(16'hFBFF, 0, 0, 2);
    rst_in = 1'b0;
    hold(16'hFBFF, 0, 0, 7);
    chk("t6 before latency", 16'(fifo_count), 16'd0);
    hold(16'hFBFF, 0, 0, 1);
    chk("t6 count", 16'(fifo_count), 16'd1);
    chk("t6 data", 16'(code_data), 16'd10);
    hold(16'hFBFF, 0, 0, 12);
    chk("t6 single event", 16'(fifo_count), 16'd1);
    hold(16'hFFFF, 0, 0, 10);
    hold(16'hFFFF, 1, 0, 1);
    chk("t6 drained", 16'(fifo_count), 16'd0);

    // Randomized run against the model.
    for (int seg = 0; seg < 250; seg++) begin
      logic [15:0] k;
      int          mode;
      int          len;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       k = 16'hFFFF;
        1:       k = one_key($urandom_range(0, 15));
        2:       k = one_key($urandom_range(0, 15)) & one_key($urandom_range(0, 15));
        default: k = 16'($urandom);
      endcase
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++)
        step(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
